// File: rtl/endat_slave_emu.sv
// EnDat slave emulator: answers mode 000111 with start bit, F1, LSB-first position and inverted CRC-5.
// Optional macro ENDAT_ALARM_EN adds an 'alarm' input that supplies F1 (otherwise F1 is 0).
module endat_slave_emu #(
   parameter int POS_BITS = 21,
   parameter int CAL_CLKS = 2,
   parameter int TM_CYC   = 2000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                endat_clk,
   input  logic                endat_din,
   input  logic [POS_BITS-1:0] position,
   input  logic                pos_valid,
`ifdef ENDAT_ALARM_EN
   input  logic                alarm,
`endif
   output logic                endat_dout,
   output logic                endat_doe,
   output logic                busy,
   output logic                mode_err,
   output logic                frame_done,
   output logic [15:0]         frame_cnt
);

   localparam int         TW       = $clog2(TM_CYC + 1);
   localparam int         CNT_MAX  = ((POS_BITS > CAL_CLKS) ? POS_BITS : CAL_CLKS) + 8;
   localparam int         CW       = $clog2(CNT_MAX);
   localparam logic [5:0] MODE_POS = 6'b000111;

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      DLY   = 4'd1,
      MODE  = 4'd2,
      CALC  = 4'd3,
      STRT  = 4'd4,
      ALM   = 4'd5,
      POS   = 4'd6,
      CRC   = 4'd7,
      RECOV = 4'd8
   } state_t;

   // One serial step of x^5+x^3+x^2+x+1, message bits entering MSB-side.
   function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic bit_in);
      logic fb;
      fb = crc[4] ^ bit_in;
      return {crc[3:0], 1'b0} ^ (fb ? 5'b01111 : 5'b00000);
   endfunction

   logic                ck_s1_q, ck_s2_q, ck_d1_q;
   logic                din_s1_q, din_s2_q;
   logic                rise_s, fall_s, edge_s, tmo_hit_s, f1_s;
   logic [POS_BITS-1:0] pos_load_s;

   state_t              state_q, state_d;
   logic [TW-1:0]       tmo_q, tmo_d;
   logic                armed_q, armed_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [5:0]          mode_q, mode_d;
   logic [POS_BITS-1:0] hold_q, hold_d;
   logic [POS_BITS-1:0] shift_q, shift_d;
   logic [4:0]          crc_q, crc_d;
   logic                dout_q, dout_d;
   logic                doe_q, doe_d;
   logic                busy_q, busy_d;
   logic                mode_err_q, mode_err_d;
   logic                frame_done_q, frame_done_d;
   logic [15:0]         frame_cnt_q, frame_cnt_d;
`ifdef ENDAT_ALARM_EN
   logic                alarm_q, alarm_d;
`endif

   assign rise_s     = ck_s2_q & ~ck_d1_q;
   assign fall_s     = ~ck_s2_q & ck_d1_q;
   assign edge_s     = rise_s | fall_s;
   assign tmo_hit_s  = (tmo_q == TW'(TM_CYC)) & ~edge_s;
   assign pos_load_s = pos_valid ? position : hold_q;
`ifdef ENDAT_ALARM_EN
   assign f1_s       = alarm_q;
`else
   assign f1_s       = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      armed_d      = armed_q;
      cnt_d        = cnt_q;
      mode_d       = mode_q;
      shift_d      = shift_q;
      crc_d        = crc_q;
      dout_d       = dout_q;
      doe_d        = doe_q;
      mode_err_d   = 1'b0;
      frame_done_d = 1'b0;
      frame_cnt_d  = frame_cnt_q;
      hold_d       = pos_valid ? position : hold_q;
`ifdef ENDAT_ALARM_EN
      alarm_d      = alarm_q;
`endif
      if (edge_s) begin
         tmo_d = '0;
      end else if (ck_s2_q && (tmo_q != TW'(TM_CYC))) begin
         tmo_d = tmo_q + TW'(1);
      end else begin
         tmo_d = tmo_q;
      end

      // A long clock-high period always wins: it ends or aborts any frame and arms IDLE.
      if (tmo_hit_s) begin
         state_d = IDLE;
         armed_d = 1'b1;
         doe_d   = 1'b0;
         dout_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               doe_d  = 1'b0;
               dout_d = 1'b0;
               if (fall_s && armed_q) begin
                  state_d = DLY;
                  armed_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
            DLY: begin
               if (fall_s) begin
                  state_d = MODE;
                  cnt_d   = '0;
               end else begin
                  state_d = DLY;
               end
            end
            MODE: begin
               if (fall_s) begin
                  mode_d = {mode_q[4:0], din_s2_q};
                  cnt_d  = cnt_q + CW'(1);
                  if (cnt_q == CW'(5)) begin
                     cnt_d  = '0;
                     dout_d = 1'b0;
                     if ({mode_q[4:0], din_s2_q} == MODE_POS) begin
                        state_d = CALC;
                        doe_d   = 1'b1;
                        shift_d = pos_load_s;
                        crc_d   = 5'b11111;
`ifdef ENDAT_ALARM_EN
                        alarm_d = alarm;
`endif
                     end else begin
                        state_d    = RECOV;
                        doe_d      = 1'b0;
                        mode_err_d = 1'b1;
                     end
                  end else begin
                     state_d = MODE;
                  end
               end else begin
                  state_d = MODE;
               end
            end
            CALC: begin
               if (rise_s) begin
                  if (cnt_q == CW'(CAL_CLKS)) begin
                     state_d = STRT;
                     dout_d  = 1'b1;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end else begin
                  state_d = CALC;
               end
            end
            STRT: begin
               if (rise_s) begin
                  state_d = ALM;
                  dout_d  = f1_s;
                  crc_d   = crc5_step(crc_q, f1_s);
               end else begin
                  state_d = STRT;
               end
            end
            ALM: begin
               if (rise_s) begin
                  state_d = POS;
                  dout_d  = shift_q[0];
                  crc_d   = crc5_step(crc_q, shift_q[0]);
                  shift_d = shift_q >> 1;
                  cnt_d   = CW'(1);
               end else begin
                  state_d = ALM;
               end
            end
            POS: begin
               if (rise_s) begin
                  if (cnt_q == CW'(POS_BITS)) begin
                     state_d = CRC;
                     dout_d  = ~crc_q[4];
                     crc_d   = {crc_q[3:0], 1'b0};
                     cnt_d   = CW'(1);
                  end else begin
                     dout_d  = shift_q[0];
                     crc_d   = crc5_step(crc_q, shift_q[0]);
                     shift_d = shift_q >> 1;
                     cnt_d   = cnt_q + CW'(1);
                  end
               end else begin
                  state_d = POS;
               end
            end
            CRC: begin
               if (rise_s) begin
                  dout_d = ~crc_q[4];
                  crc_d  = {crc_q[3:0], 1'b0};
                  cnt_d  = cnt_q + CW'(1);
                  if (cnt_q == CW'(4)) begin
                     state_d      = RECOV;
                     frame_done_d = 1'b1;
                     frame_cnt_d  = frame_cnt_q + 16'd1;
                  end else begin
                     state_d = CRC;
                  end
               end else begin
                  state_d = CRC;
               end
            end
            RECOV: begin
               // Last CRC bit stays on the line until the master's next rising edge.
               if (rise_s) begin
                  dout_d = 1'b0;
               end else begin
                  dout_d = dout_q;
               end
            end
            default: begin
               state_d = IDLE;
               doe_d   = 1'b0;
               dout_d  = 1'b0;
            end
         endcase
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ck_s1_q      <= 1'b1;
         ck_s2_q      <= 1'b1;
         ck_d1_q      <= 1'b1;
         din_s1_q     <= 1'b0;
         din_s2_q     <= 1'b0;
         state_q      <= IDLE;
         tmo_q        <= '0;
         armed_q      <= 1'b0;
         cnt_q        <= '0;
         mode_q       <= 6'b000000;
         hold_q       <= '0;
         shift_q      <= '0;
         crc_q        <= 5'b11111;
         dout_q       <= 1'b0;
         doe_q        <= 1'b0;
         busy_q       <= 1'b0;
         mode_err_q   <= 1'b0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= 16'd0;
`ifdef ENDAT_ALARM_EN
         alarm_q      <= 1'b0;
`endif
      end else begin
         ck_s1_q      <= endat_clk;
         ck_s2_q      <= ck_s1_q;
         ck_d1_q      <= ck_s2_q;
         din_s1_q     <= endat_din;
         din_s2_q     <= din_s1_q;
         state_q      <= state_d;
         tmo_q        <= tmo_d;
         armed_q      <= armed_d;
         cnt_q        <= cnt_d;
         mode_q       <= mode_d;
         hold_q       <= hold_d;
         shift_q      <= shift_d;
         crc_q        <= crc_d;
         dout_q       <= dout_d;
         doe_q        <= doe_d;
         busy_q       <= busy_d;
         mode_err_q   <= mode_err_d;
         frame_done_q <= frame_done_d;
         frame_cnt_q  <= frame_cnt_d;
`ifdef ENDAT_ALARM_EN
         alarm_q      <= alarm_d;
`endif
      end
   end

   assign endat_dout = dout_q;
   assign endat_doe  = doe_q;
   assign busy       = busy_q;
   assign mode_err   = mode_err_q;
   assign frame_done = frame_done_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_endat_slave_emu.sv
// Randomized bench for endat_slave_emu: an EnDat master at 4 MHz plus a reference model
// that builds the expected frame and CRC-5 by polynomial long division.
`timescale 1ns/1ps
module tb_endat_slave_emu;
   localparam int         POS_BITS = 21;
   localparam int         CAL_CLKS = 2;
   localparam int         TM_CYC   = 2000;
   localparam int         HALF     = 25;
   localparam int         S_IDX    = 9 + CAL_CLKS;
   localparam int         NFULL    = S_IDX + 2 + POS_BITS + 5;
   localparam logic [5:0] MODE_POS = 6'b000111;
`ifdef ENDAT_ALARM_EN
   localparam bit         HAS_ALARM = 1'b1;
`else
   localparam bit         HAS_ALARM = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst, endat_clk, endat_din, pos_valid;
   logic [POS_BITS-1:0] position;
`ifdef ENDAT_ALARM_EN
   logic                alarm;
`endif
   logic                endat_dout, endat_doe, busy, mode_err, frame_done;
   logic [15:0]         frame_cnt;

   int                  n_tests = 0, n_fail = 0;
   int                  fd_total = 0, me_total = 0, doe_total = 0;
   logic                samp   [1:64];
   logic                doe_at [1:64];
   logic [POS_BITS-1:0] exp_hold;
   logic [15:0]         exp_cnt;

   endat_slave_emu #(.POS_BITS(POS_BITS), .CAL_CLKS(CAL_CLKS), .TM_CYC(TM_CYC)) dut (
      .clk(clk), .rst(rst), .endat_clk(endat_clk), .endat_din(endat_din),
      .position(position), .pos_valid(pos_valid),
`ifdef ENDAT_ALARM_EN
      .alarm(alarm),
`endif
      .endat_dout(endat_dout), .endat_doe(endat_doe), .busy(busy),
      .mode_err(mode_err), .frame_done(frame_done), .frame_cnt(frame_cnt)
   );

   always #2.5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done) fd_total  <= fd_total + 1;
      if (mode_err)   me_total  <= me_total + 1;
      if (endat_doe)  doe_total <= doe_total + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // CRC over F1 then position LSB-first, preset 11111, as a remainder mod x^5+x^3+x^2+x+1.
   function automatic logic [4:0] ref_crc(input logic f1, input logic [POS_BITS-1:0] p);
      logic [63:0] v;
      int          len;
      len = 1 + POS_BITS;
      v   = 64'd0;
      v[len - 1 + 5] = f1;
      for (int i = 0; i < POS_BITS; i++) v[len - 2 - i + 5] = p[i];
      v = v ^ (64'h1F << len);
      for (int b = len + 4; b >= 5; b--) begin
         if (v[b]) v = v ^ (64'h2F << (b - 5));
      end
      return v[4:0];
   endfunction

   task automatic endat_frame(input logic [5:0] mode, input int nclk, input logic pv_cap,
                              input logic [POS_BITS-1:0] pv_val);
      endat_din = 1'b0;
      for (int k = 1; k <= nclk; k++) begin
         samp[k]   = endat_dout;
         doe_at[k] = endat_doe;
         endat_clk = 1'b0;
         if (k == 8 && pv_cap) begin
            repeat (2) @(negedge clk);
            position  = pv_val;
            pos_valid = 1'b1;
            @(negedge clk);
            pos_valid = 1'b0;
            repeat (HALF - 3) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
         endat_clk = 1'b1;
         endat_din = (k >= 2 && k <= 7) ? mode[7 - k] : 1'b0;
         repeat (HALF) @(negedge clk);
      end
   endtask

   task automatic load_pos(input logic [POS_BITS-1:0] v);
      position  = v;
      pos_valid = 1'b1;
      @(negedge clk);
      pos_valid = 1'b0;
      position  = POS_BITS'($urandom);
      exp_hold  = v;
      @(negedge clk);
   endtask

   task automatic good_frame(input logic pv_cap, input logic [POS_BITS-1:0] pv_val, input logic alm);
      logic [POS_BITS-1:0] exp_pos, rx_pos;
      logic [4:0]          rx_crc;
      logic                exp_f1;
      int                  fd0;
`ifdef ENDAT_ALARM_EN
      alarm = alm;
`endif
      exp_f1  = HAS_ALARM & alm;
      exp_pos = pv_cap ? pv_val : exp_hold;
      if (pv_cap) exp_hold = pv_val;
      fd0 = fd_total;
      endat_frame(MODE_POS, NFULL, pv_cap, pv_val);
      chk("mode_doe", {31'd0, doe_at[8]}, 32'd0);
      chk("calc_doe", {31'd0, doe_at[S_IDX - 1]}, 32'd1);
      for (int i = 9; i < S_IDX; i++) chk("calc_dout", {31'd0, samp[i]}, 32'd0);
      chk("start_bit", {31'd0, samp[S_IDX]}, 32'd1);
      chk("f1", {31'd0, samp[S_IDX + 1]}, {31'd0, exp_f1});
      for (int i = 0; i < POS_BITS; i++) rx_pos[i] = samp[S_IDX + 2 + i];
      chk("position", {11'd0, rx_pos}, {11'd0, exp_pos});
      for (int i = 0; i < 5; i++) rx_crc[4 - i] = samp[S_IDX + 2 + POS_BITS + i];
      chk("crc", {27'd0, rx_crc}, {27'd0, ~ref_crc(exp_f1, exp_pos)});
      chk("frame_done", fd_total - fd0, 32'd1);
      exp_cnt = exp_cnt + 16'd1;
      chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_cnt});
      repeat (TM_CYC + 50) @(negedge clk);
      chk("idle_after_tmo", {30'd0, busy, endat_doe}, 32'd0);
   endtask

   initial begin
      int fd0, me0, doe0;
      rst       = 1'b1;
      endat_clk = 1'b1;
      endat_din = 1'b0;
      position  = '0;
      pos_valid = 1'b0;
`ifdef ENDAT_ALARM_EN
      alarm     = 1'b0;
`endif
      exp_hold  = '0;
      exp_cnt   = 16'd0;
      repeat (3) @(negedge clk);
      chk("rst_outputs", {26'd0, endat_dout, endat_doe, busy, mode_err, frame_done, 1'b0}, 32'd0);
      chk("rst_cnt", {16'd0, frame_cnt}, 32'd0);
      rst = 1'b0;
      repeat (TM_CYC + 50) @(negedge clk);

      load_pos(21'h0ABCDE);
      good_frame(1'b0, '0, 1'b0);

      // Unsupported mode: error pulse, driver stays off, counter untouched.
      fd0 = fd_total; me0 = me_total; doe0 = doe_total;
      endat_frame(6'b111000, NFULL, 1'b0, '0);
      chk("err_pulse", me_total - me0, 32'd1);
      chk("err_doe", doe_total - doe0, 32'd0);
      chk("err_no_done", fd_total - fd0, 32'd0);
      chk("err_cnt", {16'd0, frame_cnt}, {16'd0, exp_cnt});
      repeat (TM_CYC + 50) @(negedge clk);
      good_frame(1'b0, '0, 1'b1);

      // Master stalls mid-position for 12 us.
      fd0 = fd_total;
      endat_frame(MODE_POS, S_IDX + 8, 1'b0, '0);
      chk("stall_doe_on", {31'd0, endat_doe}, 32'd1);
      repeat (2400) @(negedge clk);
      chk("stall_idle", {30'd0, busy, endat_doe}, 32'd0);
      chk("stall_no_done", fd_total - fd0, 32'd0);
      chk("stall_cnt", {16'd0, frame_cnt}, {16'd0, exp_cnt});
      good_frame(1'b1, POS_BITS'($urandom), 1'b0);

      // Reset while CRC bits are on the line, then an immediate frame that must be ignored.
      fd0 = fd_total;
      endat_frame(MODE_POS, S_IDX + 3 + POS_BITS, 1'b0, '0);
      chk("crc_doe_on", {31'd0, endat_doe}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_doe", {31'd0, endat_doe}, 32'd0);
      rst = 1'b0;
      exp_hold = '0;
      exp_cnt  = 16'd0;
      doe0 = doe_total;
      endat_frame(MODE_POS, NFULL, 1'b0, '0);
      chk("disarmed_doe", doe_total - doe0, 32'd0);
      chk("disarmed_done", fd_total - fd0, 32'd0);
      chk("disarmed_cnt", {16'd0, frame_cnt}, 32'd0);
      repeat (TM_CYC + 50) @(negedge clk);
      good_frame(1'b0, '0, 1'b0);

      // Counter wrap.
      @(negedge clk);
      force dut.frame_cnt_q = 16'hFFFF;
      repeat (2) @(negedge clk);
      release dut.frame_cnt_q;
      exp_cnt = 16'hFFFF;
      repeat (2) @(negedge clk);
      good_frame(1'b0, '0, 1'b1);

      for (int n = 0; n < 3; n++) begin
         load_pos(POS_BITS'($urandom));
         good_frame(1'($urandom_range(0, 1)), POS_BITS'($urandom), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
